// File: rtl/cpu_pkg.sv
// Shared definitions for the 19-bit CPU: address width, reset vector and
// the PC-control FSM state encoding.
package cpu_pkg;

  localparam int ADDR_W = 19;
  localparam logic [ADDR_W-1:0] RESET_VEC = 19'h00000;

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    HALT
  } pc_state_t;

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack: a push on a full stack overwrites the
// oldest entry; ovf/unf flag a push-while-full or pop-while-empty.
module pc_ras #(
  parameter int ADDR_W = 19,
  parameter int DEPTH  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] push_data,
  output logic [ADDR_W-1:0] top,
  output logic              empty,
  output logic              full,
  output logic              ovf,
  output logic              unf
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  logic [ADDR_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  sp_q;
  logic [PTR_W:0]    cnt_q;
  logic [PTR_W-1:0]  sp_inc;
  logic [PTR_W-1:0]  sp_dec;

  assign sp_inc = sp_q + 1'b1;
  assign sp_dec = sp_q - 1'b1;
  assign top    = mem[sp_q];
  assign empty  = (cnt_q == '0);
  assign full   = (cnt_q == FULL_CNT);
  assign ovf    = push & full;
  assign unf    = pop & empty;

  // sp_q always indexes the most recent entry; the pointer wraps freely and
  // cnt_q saturates, which yields the overwrite-oldest behaviour.
  always_ff @(posedge clk) begin
    if (rst) begin
      sp_q  <= '0;
      cnt_q <= '0;
    end else if (push) begin
      sp_q <= sp_inc;
      if (!full) cnt_q <= cnt_q + 1'b1;
    end else if (pop && !empty) begin
      sp_q  <= sp_dec;
      cnt_q <= cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[sp_inc] <= push_data;
  end

endmodule

// File: rtl/pc_ctrl.sv
// Program-counter control: architectural PC, next-PC selection and fetch
// handshake. Define PC_RAS_EN to build the return-address stack.
module pc_ctrl
  import cpu_pkg::pc_state_t, cpu_pkg::BOOT, cpu_pkg::RUN, cpu_pkg::HALT;
#(
  parameter int                ADDR_W    = cpu_pkg::ADDR_W,
  parameter logic [ADDR_W-1:0] RESET_VEC = cpu_pkg::RESET_VEC,
  parameter int                RAS_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              halt,
  input  logic              br_taken,
  input  logic [ADDR_W-1:0] br_target,
  input  logic              jmp,
  input  logic              call,
  input  logic              ret,
  input  logic [ADDR_W-1:0] jmp_addr,
  input  logic              fetch_ready,
  output logic              fetch_valid,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_plus1,
  output logic              ras_empty,
  output logic              ras_full,
  output logic              ras_err,
  output logic              halted
);

  pc_state_t         state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              ras_err_q, err_d;
  logic              push, pop, accept, ras_hit;
  logic              ras_ovf, ras_unf;
  logic [ADDR_W-1:0] ras_top;

  assign pc          = pc_q;
  assign pc_plus1    = pc_q + {{(ADDR_W-1){1'b0}}, 1'b1};
  assign fetch_valid = (state_q == RUN);
  assign halted      = (state_q == HALT);
  assign ras_err     = ras_err_q;
  assign accept      = fetch_valid & fetch_ready & !stall;

`ifdef PC_RAS_EN
  pc_ras #(
    .ADDR_W (ADDR_W),
    .DEPTH  (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .pop       (pop),
    .push_data (pc_plus1),
    .top       (ras_top),
    .empty     (ras_empty),
    .full      (ras_full),
    .ovf       (ras_ovf),
    .unf       (ras_unf)
  );
  assign ras_hit = !ras_empty;
`else
  logic unused_ras;
  assign ras_top    = '0;
  assign ras_empty  = 1'b1;
  assign ras_full   = 1'b0;
  assign ras_ovf    = 1'b0;
  assign ras_unf    = 1'b0;
  assign ras_hit    = 1'b0;
  assign unused_ras = ^{push, pop, RAS_DEPTH[0]};
`endif

  // Redirects ignore stall/fetch_ready; only the sequential advance is gated.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    err_d   = 1'b0;
    push    = 1'b0;
    pop     = 1'b0;
    case (state_q)
      BOOT: state_d = RUN;
      RUN: begin
        if (halt) begin
          state_d = HALT;
        end else if (ret) begin
          if (ras_hit) begin
            pc_d  = ras_top;
            pop   = 1'b1;
            err_d = call;
          end else begin
            err_d = 1'b1;
            if (accept) pc_d = pc_plus1;
          end
        end else if (call) begin
          pc_d = jmp_addr;
          push = 1'b1;
        end else if (jmp) begin
          pc_d = jmp_addr;
        end else if (br_taken) begin
          pc_d = br_target;
        end else if (accept) begin
          pc_d = pc_plus1;
        end
      end
      HALT: ;
      default: state_d = BOOT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= BOOT;
      pc_q      <= RESET_VEC;
      ras_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ras_err_q <= err_d | ras_ovf | ras_unf;
    end
  end

endmodule

// File: tb/tb_pc_ctrl.sv
// Directed self-checking bench for pc_ctrl; call/ret expectations follow
// whether PC_RAS_EN is defined.
module tb_pc_ctrl;

  logic        clk = 1'b0;
  logic        rst, stall, halt, br_taken, jmp, call, ret, fetch_ready;
  logic [18:0] br_target, jmp_addr;
  logic        fetch_valid, ras_empty, ras_full, ras_err, halted;
  logic [18:0] pc, pc_plus1;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  pc_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .halt        (halt),
    .br_taken    (br_taken),
    .br_target   (br_target),
    .jmp         (jmp),
    .call        (call),
    .ret         (ret),
    .jmp_addr    (jmp_addr),
    .fetch_ready (fetch_ready),
    .fetch_valid (fetch_valid),
    .pc          (pc),
    .pc_plus1    (pc_plus1),
    .ras_empty   (ras_empty),
    .ras_full    (ras_full),
    .ras_err     (ras_err),
    .halted      (halted)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ctrl();
    stall = 0; halt = 0; br_taken = 0; jmp = 0; call = 0; ret = 0;
  endtask

  task automatic test_reset();
    rst = 1; fetch_ready = 1; br_target = '0; jmp_addr = '0;
    clear_ctrl();
    step(); step();
    total++; if (pc !== 19'h00000) $display("FAIL reset_pc got=%h exp=%h", pc, 19'h00000); else passed++;
    total++; if (fetch_valid !== 1'b0) $display("FAIL reset_fv got=%b exp=0", fetch_valid); else passed++;
    total++; if (ras_empty !== 1'b1) $display("FAIL reset_empty got=%b exp=1", ras_empty); else passed++;
    total++; if (ras_full !== 1'b0) $display("FAIL reset_full got=%b exp=0", ras_full); else passed++;
    total++; if (ras_err !== 1'b0) $display("FAIL reset_err got=%b exp=0", ras_err); else passed++;
    total++; if (halted !== 1'b0) $display("FAIL reset_halted got=%b exp=0", halted); else passed++;
    rst = 0;
    #1;
    total++; if (fetch_valid !== 1'b0 || pc !== 19'h0) $display("FAIL boot_cycle fv=%b pc=%h exp fv=0 pc=0", fetch_valid, pc); else passed++;
    step();
    total++; if (fetch_valid !== 1'b1 || pc !== 19'h0) $display("FAIL run_first fv=%b pc=%h exp fv=1 pc=0", fetch_valid, pc); else passed++;
    step();
    total++; if (pc !== 19'h00001) $display("FAIL seq_1 got=%h exp=%h", pc, 19'h00001); else passed++;
    step();
    total++; if (pc !== 19'h00002) $display("FAIL seq_2 got=%h exp=%h", pc, 19'h00002); else passed++;
  endtask

  task automatic test_stall();
    jmp = 1; jmp_addr = 19'h00010; step(); jmp = 0;
    total++; if (pc !== 19'h00010) $display("FAIL stall_setup got=%h exp=%h", pc, 19'h00010); else passed++;
    stall = 1; step(); step();
    total++; if (pc !== 19'h00010) $display("FAIL stall_hold got=%h exp=%h", pc, 19'h00010); else passed++;
    stall = 0; fetch_ready = 0; step();
    total++; if (pc !== 19'h00010 || fetch_valid !== 1'b1) $display("FAIL notready_hold pc=%h fv=%b exp pc=00010 fv=1", pc, fetch_valid); else passed++;
    br_taken = 1; br_target = 19'h00100; step(); br_taken = 0;
    total++; if (pc !== 19'h00100) $display("FAIL br_during_hold got=%h exp=%h", pc, 19'h00100); else passed++;
    fetch_ready = 1; step();
    total++; if (pc !== 19'h00101) $display("FAIL resume_seq got=%h exp=%h", pc, 19'h00101); else passed++;
  endtask

  task automatic test_priority();
    jmp = 1; jmp_addr = 19'h02000; br_taken = 1; br_target = 19'h00300; step();
    clear_ctrl();
    total++; if (pc !== 19'h02000) $display("FAIL jmp_over_br got=%h exp=%h", pc, 19'h02000); else passed++;
    br_taken = 1; br_target = 19'h00300; stall = 1; step();
    clear_ctrl();
    total++; if (pc !== 19'h00300) $display("FAIL br_with_stall got=%h exp=%h", pc, 19'h00300); else passed++;
  endtask

  task automatic test_wrap();
    jmp = 1; jmp_addr = 19'h7FFFF; step(); jmp = 0;
    total++; if (pc_plus1 !== 19'h00000) $display("FAIL plus1_wrap got=%h exp=%h", pc_plus1, 19'h00000); else passed++;
    step();
    total++; if (pc !== 19'h00000) $display("FAIL pc_wrap got=%h exp=%h", pc, 19'h00000); else passed++;
    total++; if (ras_err !== 1'b0) $display("FAIL wrap_err got=%b exp=0", ras_err); else passed++;
  endtask

  task automatic test_call_ret();
    jmp = 1; jmp_addr = 19'h00040; step(); jmp = 0;
    call = 1; jmp_addr = 19'h01000; step(); call = 0;
    total++; if (pc !== 19'h01000) $display("FAIL call_target got=%h exp=%h", pc, 19'h01000); else passed++;
`ifdef PC_RAS_EN
    total++; if (ras_empty !== 1'b0) $display("FAIL call_nonempty got=%b exp=0", ras_empty); else passed++;
    ret = 1; step(); ret = 0;
    total++; if (pc !== 19'h00041 || ras_err !== 1'b0) $display("FAIL ret_target pc=%h err=%b exp pc=00041 err=0", pc, ras_err); else passed++;
    step();
    for (int i = 1; i <= 9; i++) begin
      call = 1; jmp_addr = 19'(i * 'h100); step();
      total++; if (ras_err !== (i == 9)) $display("FAIL push_err_%0d got=%b exp=%b", i, ras_err, (i == 9)); else passed++;
      if (i == 8) begin
        total++; if (ras_full !== 1'b1) $display("FAIL full_after_8 got=%b exp=1", ras_full); else passed++;
      end
    end
    call = 0; step();
    total++; if (ras_err !== 1'b0 || ras_full !== 1'b1 || pc !== 19'h00901) $display("FAIL after_ovf err=%b full=%b pc=%h exp err=0 full=1 pc=00901", ras_err, ras_full, pc); else passed++;
    ret = 1; step();
    total++; if (pc !== 19'h00801) $display("FAIL ret_after_ovf got=%h exp=%h", pc, 19'h00801); else passed++;
    call = 1; jmp_addr = 19'h05555; step();
    clear_ctrl();
    total++; if (pc !== 19'h00701 || ras_err !== 1'b1) $display("FAIL call_and_ret pc=%h err=%b exp pc=00701 err=1", pc, ras_err); else passed++;
    step();
    total++; if (ras_err !== 1'b0 || ras_full !== 1'b0 || pc !== 19'h00702) $display("FAIL err_one_cycle err=%b full=%b pc=%h exp err=0 full=0 pc=00702", ras_err, ras_full, pc); else passed++;
`else
    total++; if (ras_empty !== 1'b1 || ras_full !== 1'b0) $display("FAIL tied_flags empty=%b full=%b exp empty=1 full=0", ras_empty, ras_full); else passed++;
    ret = 1; step(); ret = 0;
    total++; if (pc !== 19'h01001 || ras_err !== 1'b1) $display("FAIL ret_no_ras pc=%h err=%b exp pc=01001 err=1", pc, ras_err); else passed++;
    step();
    total++; if (ras_err !== 1'b0 || pc !== 19'h01002) $display("FAIL err_one_cycle err=%b pc=%h exp err=0 pc=01002", ras_err, pc); else passed++;
    call = 1; jmp_addr = 19'h03000; step(); call = 0;
    total++; if (pc !== 19'h03000 || ras_err !== 1'b0) $display("FAIL call_as_jmp pc=%h err=%b exp pc=03000 err=0", pc, ras_err); else passed++;
`endif
  endtask

  task automatic test_halt_underflow();
    rst = 1; step(); rst = 0; step();
    jmp = 1; jmp_addr = 19'h00005; step(); jmp = 0;
    total++; if (pc !== 19'h00005 || ras_empty !== 1'b1) $display("FAIL uf_setup pc=%h empty=%b exp pc=00005 empty=1", pc, ras_empty); else passed++;
    ret = 1; step(); ret = 0;
    total++; if (pc !== 19'h00006 || ras_err !== 1'b1) $display("FAIL underflow pc=%h err=%b exp pc=00006 err=1", pc, ras_err); else passed++;
    step();
    total++; if (ras_err !== 1'b0 || pc !== 19'h00007) $display("FAIL uf_one_cycle err=%b pc=%h exp err=0 pc=00007", ras_err, pc); else passed++;
    halt = 1; jmp = 1; jmp_addr = 19'h01234; step();
    total++; if (halted !== 1'b1 || fetch_valid !== 1'b0 || pc !== 19'h00007) $display("FAIL halt_enter halted=%b fv=%b pc=%h exp 1 0 00007", halted, fetch_valid, pc); else passed++;
    halt = 0; br_taken = 1; br_target = 19'h00abc; step(); step();
    total++; if (halted !== 1'b1 || pc !== 19'h00007) $display("FAIL halt_frozen halted=%b pc=%h exp 1 00007", halted, pc); else passed++;
    clear_ctrl(); rst = 1; step(); rst = 0;
    total++; if (halted !== 1'b0 || pc !== 19'h00000 || fetch_valid !== 1'b0) $display("FAIL halt_rst halted=%b pc=%h fv=%b exp 0 00000 0", halted, pc, fetch_valid); else passed++;
  endtask

  initial begin
    test_reset();
    test_stall();
    test_priority();
    test_wrap();
    test_call_ret();
    test_halt_underflow();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/pc_ctrl.md
# pc_ctrl

Program-counter control stage for the 19-bit CPU. Holds the architectural PC register and selects the next PC from sequential increment, PC-relative branch target (produced by the `pc_addr` adder), absolute jump, or call/return. It sits directly downstream of `pc_addr`, consuming its sum as `br_target`, and upstream of instruction fetch, which it drives through a valid/ready handshake.

## Interface
- `ADDR_W`, 19: PC width; all address arithmetic is modulo 2^ADDR_W.
- `RESET_VEC`, 19'h00000: PC value loaded by reset.
- `RAS_DEPTH`, 8: return-address-stack entries; power of two, at least 2. Used only with `PC_RAS_EN`.

- `clk`  in  1  sole clock; rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `stall`  in  1  hold the sequential advance.
- `halt`  in  1  enter HALT; exit only by `rst`.
- `br_taken`  in  1  load `br_target`.
- `br_target`  in  19  PC-relative target from `pc_addr` output `c`.
- `jmp`  in  1  load `jmp_addr`.
- `call`  in  1  push PC+1, then load `jmp_addr`.
- `ret`  in  1  pop the top of the stack into PC.
- `jmp_addr`  in  19  absolute target for `jmp` and `call`.
- `fetch_ready`  in  1  fetch accepts `pc`.
- `fetch_valid`  out  1  `pc` is a valid fetch address.
- `pc`  out  19  current PC; registered.
- `pc_plus1`  out  19  combinational `pc`+1, wrapping.
- `ras_empty`  out  1  stack empty.
- `ras_full`  out  1  stack full.
- `ras_err`  out  1  one-cycle pulse on stack overflow, underflow, or illegal call+ret.
- `halted`  out  1  FSM is in HALT.

## Operation
**FSM states:** BOOT, RUN, HALT.
- `rst` forces BOOT.
- BOOT moves to RUN after one cycle. `fetch_valid` is 0 in BOOT.
- From RUN, `halt`=1 moves to HALT. HALT holds `pc`, drives `fetch_valid`=0, and ignores every other input.

**Next-PC priority in RUN:** `halt` > `ret` > `call` > `jmp` > `br_taken` > sequential.
- A redirect (`ret`, `call`, `jmp`, `br_taken`) applies regardless of `stall` or `fetch_ready`. It overrides any held fetch.
- Sequential advance (`pc` <= `pc_plus1`) happens only when `fetch_valid & fetch_ready & !stall`. Otherwise `pc` holds.

**Wrap-around:** 0x7FFFF + 1 = 0x00000, with no flag. Targets are taken as-is; no alignment check.

**`call`:** pushes `pc_plus1` and loads `jmp_addr`.
- A push on a full stack overwrites the oldest entry (circular) and pulses `ras_err`.

**`ret`:** loads the popped top of the stack.
- A `ret` on an empty stack pulses `ras_err` and takes the sequential path instead.
- `call` and `ret` in the same cycle: `ret` is honoured, there is no push, and `ras_err` pulses.

**`rst` mid-operation:** `rst` at any cycle discards pending redirects and clears the stack.

## Timing
- **Reset values:** `pc`=`RESET_VEC`, `fetch_valid`=0, `ras_empty`=1, `ras_full`=0, `ras_err`=0, `halted`=0.
- **Redirect latency:** a redirect sampled at edge N appears on `pc` after edge N, with `fetch_valid`=1 in that cycle. There is no bubble.
- `pc_plus1` is combinational from `pc`.
- Inputs are sampled only at rising edges. There is no combinational path from any control input to `pc` or `fetch_valid`.
- `ras_err` is registered and lasts exactly one cycle per event.
- **Handshake:** `pc` stays stable while `fetch_valid & !fetch_ready`, unless a redirect occurs.

## Configuration
- **`PC_RAS_EN` defined:** the return-address stack is built, of depth `RAS_DEPTH`, with the `call`/`ret` behaviour described above.
- **`PC_RAS_EN` undefined:**
  - `call` behaves exactly as `jmp` (no push).
  - `ret` takes the sequential path and pulses `ras_err`.
  - `ras_empty` is tied to 1 and `ras_full` to 0.
  - No stack storage is synthesised.

## Structure
- **Shared package `cpu_pkg`:** `ADDR_W`=19, `RESET_VEC`, and the `pc_state_t` enum (BOOT, RUN, HALT).
- **Sub-module `pc_ras`:** circular stack with push/pop, full/empty and overflow/underflow flags. It is instantiated only under `PC_RAS_EN`.

## Test plan
- **Reset and boot:** assert `rst` for 2 cycles, then release with `fetch_ready`=1 → `pc`=0x00000 and `fetch_valid`=0 for one cycle, then `pc` reads 0x00001, 0x00002, …
- **Stall and handshake:** set `stall`=1 or `fetch_ready`=0 at `pc`=0x00010 → `pc` holds 0x00010. Raise `br_taken` with `br_target`=0x00100 during the stall → `pc`=0x00100 on the next cycle.
- **Priority:** `jmp`=1 (`jmp_addr`=0x02000) and `br_taken`=1 (`br_target`=0x00300) in the same cycle → `pc`=0x02000.
- **Wrap:** `jmp` to 0x7FFFF, then one accepted fetch → `pc`=0x00000 and `ras_err`=0.
- **Call/return:** `call` at `pc`=0x00040 with `jmp_addr`=0x01000, then `ret` → `pc`=0x01000, then 0x00041. Push 9 calls with `RAS_DEPTH`=8 → `ras_err` pulses on the 9th call and `ras_full`=1.
- **Halt and underflow:** `ret` on an empty stack at `pc`=0x00005 → `pc`=0x00006 with a one-cycle `ras_err`. `halt` → `halted`=1, `fetch_valid`=0, `pc` frozen until `rst`.
